// File: rtl/viterbi_decoder.sv
// viterbi_decoder: hard-decision K=7 rate-1/2 (133/171) Viterbi decoder
// 64-state ACS array, register-exchange survivors, fixed-depth decode from state 0.
module viterbi_decoder #(
   parameter int TB_DEPTH = 40,
   parameter int METRIC_W = 8
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Input,
   input  logic InValid,
   output logic Output,
   output logic OutValid
);
   localparam int CW = $clog2(TB_DEPTH + 1);
   logic phase, a_bit, step, stepped;
   logic [CW-1:0] cnt;
   logic [METRIC_W-1:0] pm [64];
   logic [METRIC_W-1:0] pm_nxt [64];
   logic [TB_DEPTH-1:0] surv [64];
   logic [TB_DEPTH-1:0] surv_nxt [64];

   assign step = InValid && phase;

   function automatic logic [METRIC_W-1:0] bm(input logic [5:0] s, input logic u, input logic ra, input logic rb);
      logic ea, eb;
      ea = u ^ s[4] ^ s[3] ^ s[1] ^ s[0];
      eb = u ^ s[5] ^ s[4] ^ s[3] ^ s[0];
      return METRIC_W'(ea ^ ra) + METRIC_W'(eb ^ rb);
   endfunction

   // Wrap-around metrics: the sign of the modular difference picks the smaller candidate.
   for (genvar i = 0; i < 64; i++) begin : g_acs
      localparam logic [5:0] N = 6'(i);
      localparam logic [5:0] S0 = {N[4:0], 1'b0};
      localparam logic [5:0] S1 = {N[4:0], 1'b1};
      logic [METRIC_W-1:0] c0, c1, d;
      assign c0 = pm[S0] + bm(S0, N[5], a_bit, Input);
      assign c1 = pm[S1] + bm(S1, N[5], a_bit, Input);
      assign d = c1 - c0;
      assign pm_nxt[i] = d[METRIC_W-1] ? c1 : c0;
      assign surv_nxt[i] = {d[METRIC_W-1] ? surv[S1][TB_DEPTH-2:0] : surv[S0][TB_DEPTH-2:0], N[5]};
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         phase <= 1'b0;
         a_bit <= 1'b0;
         stepped <= 1'b0;
         cnt <= '0;
         Output <= 1'b0;
         OutValid <= 1'b0;
         for (int j = 0; j < 64; j++) begin
            pm[j] <= (j == 0) ? '0 : METRIC_W'(1) << (METRIC_W - 2);
            surv[j] <= '0;
         end
      end else begin
         if (InValid) phase <= !phase;
         if (InValid && !phase) a_bit <= Input;
         if (step) begin
            pm <= pm_nxt;
            surv <= surv_nxt;
            if (cnt != CW'(TB_DEPTH)) cnt <= cnt + 1'b1;
         end
         stepped <= step;
         if (stepped) Output <= surv[0][TB_DEPTH-1];
         OutValid <= stepped && cnt >= CW'(TB_DEPTH);
      end
   end
endmodule
